// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] BLANK_NIBBLE = 4'd0;

endpackage

// File: rtl/scan_tick_gen.sv
// Cycle counter for the scan FSM; flags the last cycle of a DRIVE or GUARD interval.
module scan_tick_gen #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic drive_done,
  output logic guard_done
);

  localparam int unsigned MaxCnt = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);

  logic [CntW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign drive_done = (count == DriveLast);
  assign guard_done = (count == GuardLast);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared decoder, with guard gaps
// between digits and tear-free display updates committed at frame boundaries.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_suppress,
  output logic [0:3]              dec,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    load_ack,
  output logic                    frame_start
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [3:0]              dec_q, dec_d;
  logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;
  logic                    ack_q, ack_d;
  logic                    fs_q, fs_d;

  logic drive_done, guard_done, leave_state, wrap;
  logic [3:0] nib;

  // A digit is blanked if undecodable, or if it and every higher digit are zero.
  function automatic logic digit_blank(input logic [4*NUM_DIGITS-1:0] val, input int i,
                                       input logic lz);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= i && val[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
    return (val[4*i +: 4] > BCD_MAX) || (lz && i != 0 && upper_zero);
  endfunction

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .clear     (leave_state),
    .drive_done(drive_done),
    .guard_done(guard_done)
  );

  assign leave_state = (state_q == DRIVE) ? drive_done : guard_done;
  assign wrap        = (state_q == GUARD) && guard_done && (idx_q == LastIdx);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    ack_d           = 1'b0;
    fs_d            = 1'b0;

    if (leave_state) begin
      if (state_q == DRIVE) begin
        state_d = GUARD;
      end else begin
        state_d = DRIVE;
        idx_d   = wrap ? '0 : idx_q + 1'b1;
      end
    end

    if (wrap) begin
      fs_d = 1'b1;
      if (pending_valid_q) begin
        active_d        = pending_q;
        pending_valid_d = 1'b0;
        ack_d           = 1'b1;
      end
    end

    // A load on the commit edge becomes the next pending value.
    if (load) begin
      pending_d       = bcd_in;
      pending_valid_d = 1'b1;
    end

    nib    = active_d[4*int'(idx_d) +: 4];
    dec_d  = BLANK_NIBBLE;
    en_n_d = '1;
    if (state_d == DRIVE && !digit_blank(active_d, int'(idx_d), lz_suppress)) begin
      dec_d              = nib;
      en_n_d[int'(idx_d)] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= GUARD;
      idx_q           <= LastIdx;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      dec_q           <= BLANK_NIBBLE;
      en_n_q          <= '1;
      ack_q           <= 1'b0;
      fs_q            <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      dec_q           <= dec_d;
      en_n_q          <= en_n_d;
      ack_q           <= ack_d;
      fs_q            <= fs_d;
    end
  end

  assign dec         = dec_q;
  assign digit_en_n  = en_n_q;
  assign load_ack    = ack_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position model checked every cycle plus directed scenarios.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 2;
  localparam int SLOT  = R + G;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   bcd_in = 16'h0;
  logic          lz_suppress = 1'b0;
  logic [0:3]    dec;
  logic [N-1:0]  digit_en_n;
  logic          load_ack;
  logic          frame_start;

  int errors = 0;
  int checks = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .GUARD_CYCLES(G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .bcd_in     (bcd_in),
    .lz_suppress(lz_suppress),
    .dec        (dec),
    .digit_en_n (digit_en_n),
    .load_ack   (load_ack),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the last reset edge; position in the frame derives everything.
  int          k = 0;
  bit          m_valid = 0;
  logic [15:0] m_active = 16'h0, m_pending = 16'h0;
  bit          m_pv = 0;
  bit          exp_ack = 0;
  logic        m_lz = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; k = 0; m_active = 16'h0; m_pending = 16'h0; m_pv = 0; exp_ack = 0;
      m_lz = lz_suppress;
    end else if (m_valid) begin
      k++;
      exp_ack = 0;
      m_lz = lz_suppress;
      if (k >= G && ((k - G) % FRAME) == 0 && m_pv) begin
        m_active = m_pending; m_pv = 0; exp_ack = 1;
      end
      if (load) begin
        m_pending = bcd_in; m_pv = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_dec, nib, a_dec;
    logic [3:0] e_en;
    logic       e_fs, blank;
    int m, d;
    if (m_valid) begin
      e_dec = 4'd0; e_en = 4'hF; e_fs = 1'b0;
      if (k >= G) begin
        m = (k - G) % FRAME;
        d = m / SLOT;
        e_fs = (m == 0);
        if ((m % SLOT) < R) begin
          nib   = 4'((m_active >> (4 * d)) & 16'hF);
          blank = (nib > 4'd9) || (m_lz && d != 0 && (m_active >> (4 * d)) == 16'h0);
          if (!blank) begin
            e_dec = nib;
            e_en  = ~(4'b1 << d);
          end
        end
      end
      a_dec = dec;
      check("model_dec", 32'(a_dec), 32'(e_dec));
      check("model_en", 32'(digit_en_n), 32'(e_en));
      check("model_fs", 32'(frame_start), 32'(e_fs));
      check("model_ack", 32'(load_ack), 32'(exp_ack));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int acks);
    acks = 0;
    repeat (n) begin
      step(1);
      acks += int'(load_ack);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load = 1'b1; bcd_in = v;
    step(1);
    load = 1'b0;
  endtask

  // which = 0: frame_start, 1: load_ack
  task automatic wait_for(input bit which, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if ((which ? load_ack : frame_start) === 1'b1) begin
        ok = 1;
        break;
      end
      step(1);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic frame_scan(output logic [3:0] mask, output logic [15:0] decs);
    logic [3:0] dv;
    mask = 4'h0; decs = 16'h0;
    for (int i = 0; i < FRAME; i++) begin
      dv = dec;
      for (int j = 0; j < N; j++) begin
        if (digit_en_n[j] == 1'b0) begin
          mask[j] = 1'b1;
          decs[4*j +: 4] = dv;
        end
      end
      step(1);
    end
  endtask

  initial begin
    logic [3:0]  mask;
    logic [15:0] decs;
    logic [3:0]  dv;
    int acks;

    // 1. reset and idle scan
    step(3);
    reset = 1'b0;
    check("rst_en", 32'(digit_en_n), 32'hF);
    dv = dec; check("rst_dec", 32'(dv), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    step(1);
    check("gap0_en", 32'(digit_en_n), 32'hF);
    step(1);
    check("first_en", 32'(digit_en_n), 32'hE);
    check("first_fs", 32'(frame_start), 32'h1);
    step(1);
    check("first_fs_drop", 32'(frame_start), 32'h0);
    step(3);
    check("gap1_en", 32'(digit_en_n), 32'hF);
    step(2);
    check("d1_en", 32'(digit_en_n), 32'hD);
    step(SLOT);
    check("d2_en", 32'(digit_en_n), 32'hB);
    step(SLOT);
    check("d3_en", 32'(digit_en_n), 32'h7);

    // 2. mid-frame load of 1234
    pulse_load(16'h1234);
    wait_for(1'b1, "ack_1234_seen");
    check("ack_with_fs", 32'(frame_start), 32'h1);
    dv = dec; check("d0_dec_4", 32'(dv), 32'h4);
    check("d0_en_1234", 32'(digit_en_n), 32'hE);
    step(R);
    check("gap_1234", 32'(digit_en_n), 32'hF);
    step(G);
    dv = dec; check("d1_dec_3", 32'(dv), 32'h3);
    step(SLOT);
    dv = dec; check("d2_dec_2", 32'(dv), 32'h2);
    step(SLOT);
    dv = dec; check("d3_dec_1", 32'(dv), 32'h1);
    check("d3_en_1234", 32'(digit_en_n), 32'h7);

    // 3. leading-zero suppression
    lz_suppress = 1'b1;
    pulse_load(16'h0050);
    wait_for(1'b1, "ack_0050_seen");
    frame_scan(mask, decs);
    check("lz_mask", 32'(mask), 32'h3);
    check("lz_dec1", 32'(decs[7:4]), 32'h5);
    check("lz_dec0", 32'(decs[3:0]), 32'h0);
    lz_suppress = 1'b0;
    frame_scan(mask, decs);
    check("nolz_mask", 32'(mask), 32'hF);

    // 4. non-BCD nibble blanks only its own digit
    pulse_load(16'h1A34);
    wait_for(1'b1, "ack_1A34_seen");
    frame_scan(mask, decs);
    check("bad_mask", 32'(mask), 32'hB);
    check("bad_decs", 32'(decs), 32'h1034);

    // 5. last load wins; load on the commit edge
    wait_for(1'b0, "fs_before_1111");
    step(2);
    pulse_load(16'h1111);
    step(2);
    pulse_load(16'h2222);
    run(FRAME - 7, acks);
    check("no_early_ack", 32'(acks), 32'd0);
    load = 1'b1; bcd_in = 16'h3333;
    step(1);
    load = 1'b0;
    check("ack_2222", 32'(load_ack), 32'h1);
    check("ack_2222_fs", 32'(frame_start), 32'h1);
    dv = dec; check("dec_2222", 32'(dv), 32'h2);
    run(FRAME - 1, acks);
    check("single_ack", 32'(acks), 32'd0);
    step(1);
    check("ack_3333", 32'(load_ack), 32'h1);
    dv = dec; check("dec_3333", 32'(dv), 32'h3);

    // 6. reset drops the pending value
    wait_for(1'b0, "fs_before_reset");
    pulse_load(16'h9999);
    check("pre_reset_drive", 32'(digit_en_n), 32'hE);
    reset = 1'b1;
    step(1);
    check("reset_en_off", 32'(digit_en_n), 32'hF);
    check("reset_no_ack", 32'(load_ack), 32'h0);
    step(2);
    reset = 1'b0;
    run(2 * FRAME, acks);
    check("post_reset_acks", 32'(acks), 32'd0);
    frame_scan(mask, decs);
    check("post_reset_mask", 32'(mask), 32'hF);
    check("post_reset_decs", 32'(decs), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
